// File: rtl/conv_stream_host.sv
// conv_stream_host
// Far-end partner of a streaming convolution engine. It sends one preloaded
// X vector of N samples over a valid/ready master port. It then takes the
// N-M+1 Y results over a valid/ready slave port, storing each result and
// keeping a full-precision running sum. The host loads X and reads Y through
// simple buffer ports. Each start request runs exactly one vector.

module conv_stream_host #(
  parameter int T = 8,    // sample width (signed)
  parameter int N = 128,  // X vector length
  parameter int M = 32    // filter length
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           h_wr_en,
  input  logic [$clog2(N)-1:0]           h_wr_addr,
  input  logic [T-1:0]                   h_wr_data,
  input  logic [$clog2(N-M+1)-1:0]       h_rd_addr,
  output logic [T-1:0]                   h_rd_data,
  input  logic                           start,
  input  logic                           y_ready_en,
  output logic                           m_valid_x,
  output logic [T-1:0]                   m_data_x,
  input  logic                           m_ready_x,
  input  logic                           s_valid_y,
  input  logic [T-1:0]                   s_data_y,
  output logic                           s_ready_y,
  output logic                           busy,
  output logic                           done,
  output logic [$clog2(N-M+2)-1:0]       y_count,
  output logic [T+$clog2(N-M+1)-1:0]     y_sum
);

  localparam int NUM_Y = N - M + 1;
  localparam int AW_X  = $clog2(N);
  localparam int AW_Y  = $clog2(NUM_Y);
  localparam int CW    = $clog2(NUM_Y + 1);
  localparam int SW    = T + $clog2(NUM_Y);

  localparam logic [AW_X-1:0] TX_LAST = AW_X'(N - 1);
  localparam logic [AW_Y-1:0] RX_LAST = AW_Y'(NUM_Y - 1);

  typedef enum logic [1:0] {IDLE, SEND, RECV, DONE} state_t;

  state_t state, state_nx;

  logic [T-1:0]    xbuf [0:N-1];
  logic [T-1:0]    ybuf [0:NUM_Y-1];
  logic [AW_X-1:0] tx_ptr;
  logic [AW_Y-1:0] rx_ptr;
  logic            x_hs;
  logic            y_hs;

  assign x_hs     = m_valid_x & m_ready_x;
  assign y_hs     = s_valid_y & s_ready_y;
  // The X beat is read straight from the buffer, so the data stays stable
  // for as long as tx_ptr holds during a stall.
  assign m_data_x = xbuf[tx_ptr];

  // State register.
  // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state logic: run one vector out, collect NUM_Y results, pulse done.
  // NOTE: the default assignment comes first, so no path leaves state_nx unassigned and no latch is inferred.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = SEND;
      SEND:    if (x_hs && (tx_ptr == TX_LAST)) state_nx = RECV;
      RECV:    if (y_hs && (rx_ptr == RX_LAST)) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs decoded from state. The Y ready signal only opens while receiving.
  always_comb begin
    m_valid_x = 1'b0;
    s_ready_y = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      SEND:    begin m_valid_x = 1'b1; busy = 1'b1; end
      RECV:    begin s_ready_y = y_ready_en; busy = 1'b1; end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Pointers and statistics. These are cleared by an accepted start, advanced
  // by handshakes, and held otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_ptr  <= '0;
      rx_ptr  <= '0;
      y_count <= '0;
      y_sum   <= '0;
    end else begin
      if ((state == IDLE) && start) begin
        tx_ptr  <= '0;
        rx_ptr  <= '0;
        y_count <= '0;
        y_sum   <= '0;
      end
      if (x_hs) tx_ptr <= tx_ptr + AW_X'(1);
      if (y_hs) begin
        rx_ptr  <= rx_ptr + AW_Y'(1);
        y_count <= y_count + CW'(1);
        y_sum   <= y_sum + {{(SW-T){s_data_y[T-1]}}, s_data_y};
      end
    end
  end

  // Sample buffers. The host writes X only while idle; the engine writes Y on each accepted beat.
  // NOTE: the buffers are deliberately not reset; their contents are defined by writes, and a reset would block RAM inference.
  always_ff @(posedge clk) begin
    if ((state == IDLE) && h_wr_en) xbuf[h_wr_addr] <= h_wr_data;
    if (y_hs)                       ybuf[rx_ptr]    <= s_data_y;
  end

  // Registered host read port. A read that coincides with a write returns the old contents.
  always_ff @(posedge clk) begin
    if (reset) h_rd_data <= '0;
    else       h_rd_data <= ybuf[h_rd_addr];
  end

endmodule

// File: tb/tb_conv_stream_host.sv
// Testbench for conv_stream_host. The bench plays the engine on both streams.
// It uses random back-pressure and data, and checks the DUT against a simple
// array/queue model of the expected X sequence and the expected Y results.

module tb_conv_stream_host;

  localparam int T     = 8;
  localparam int N     = 128;
  localparam int M     = 32;
  localparam int NUM_Y = N - M + 1;

  logic                          clk = 1'b0;
  logic                          reset;
  logic                          h_wr_en;
  logic [$clog2(N)-1:0]          h_wr_addr;
  logic [T-1:0]                  h_wr_data;
  logic [$clog2(NUM_Y)-1:0]      h_rd_addr;
  logic [T-1:0]                  h_rd_data;
  logic                          start;
  logic                          y_ready_en;
  logic                          m_valid_x;
  logic [T-1:0]                  m_data_x;
  logic                          m_ready_x;
  logic                          s_valid_y;
  logic [T-1:0]                  s_data_y;
  logic                          s_ready_y;
  logic                          busy;
  logic                          done;
  logic [$clog2(NUM_Y+1)-1:0]    y_count;
  logic [T+$clog2(NUM_Y)-1:0]    y_sum;

  conv_stream_host #(.T(T), .N(N), .M(M)) dut (
    .clk(clk), .reset(reset),
    .h_wr_en(h_wr_en), .h_wr_addr(h_wr_addr), .h_wr_data(h_wr_data),
    .h_rd_addr(h_rd_addr), .h_rd_data(h_rd_data),
    .start(start), .y_ready_en(y_ready_en),
    .m_valid_x(m_valid_x), .m_data_x(m_data_x), .m_ready_x(m_ready_x),
    .s_valid_y(s_valid_y), .s_data_y(s_data_y), .s_ready_y(s_ready_y),
    .busy(busy), .done(done), .y_count(y_count), .y_sum(y_sum)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int xm [N];      // expected X vector
  int yq [NUM_Y];  // Y results the emulated engine produces, in order

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_x();
    for (int i = 0; i < N; i++) begin
      h_wr_en   = 1'b1;
      h_wr_addr = 7'(i);
      h_wr_data = 8'(xm[i]);
      tick();
    end
    h_wr_en = 1'b0;
  endtask

  // Read back every stored Y through the registered port. The value for the
  // address set in one cycle shows up one cycle later.
  task automatic read_back();
    for (int i = 0; i <= NUM_Y; i++) begin
      h_rd_addr = (i < NUM_Y) ? 7'(i) : 7'(0);
      @(negedge clk);
      if (i > 0) check("ybuf_read", int'($signed(h_rd_data)), yq[i-1]);
      tick();
    end
  endtask

  // One run as seen from the engine side.
  //   toggle_ready : m_ready_x follows 1,0,0,... instead of constant 1
  //   pokes        : extra start pulses, a busy host write and junk Y valid during SEND
  //   wr_start     : host write of x[0] in the same cycle as start
  //   abort_at     : if >0, reset after this many X beats
  task automatic do_run(input bit toggle_ready, input bit pokes, input bit wr_start, input int abort_at);
    int cyc = 0, xb = 0, yi = 0, done_cnt = 0, after = 0, prev_data = 0, exp_sum = 0;
    bit prev_stall = 0, busy_seen = 0, finished = 0, poked = 0;
    while (!finished && cyc < 3000) begin
      start   = (cyc == 0) || (pokes && cyc == 10);
      if (pokes && xb == N && yi == 20 && !poked) begin
        start = 1'b1;
        poked = 1'b1;
      end
      h_wr_en = 1'b0;
      if (cyc == 0 && wr_start) begin
        h_wr_en = 1'b1; h_wr_addr = 7'(0); h_wr_data = 8'(xm[0]);
      end
      if (pokes && cyc == 5) begin
        h_wr_en = 1'b1; h_wr_addr = 7'(N-1); h_wr_data = 8'(~xm[N-1]);
      end
      m_ready_x = toggle_ready ? (cyc % 3 == 1) : 1'b1;
      if (xb < N) begin
        s_valid_y  = pokes;
        s_data_y   = 8'h5A;
        y_ready_en = 1'b1;
      end else begin
        s_valid_y  = (yi < NUM_Y) && ($urandom_range(0, 3) != 0);
        s_data_y   = (yi < NUM_Y) ? 8'(yq[yi]) : 8'h00;
        y_ready_en = ($urandom_range(0, 9) >= 3);
      end

      @(negedge clk);
      if (xb == N && !busy_seen && done_cnt == 0) begin
        busy_seen = 1'b1;
        check("busy_in_recv", int'(busy), 1);
        check("valid_x_in_recv", int'(m_valid_x), 0);
      end
      if (xb < N) check("s_ready_y_outside_recv", int'(s_ready_y), 0);
      if (m_valid_x) begin
        if (prev_stall) check("x_stall_hold", int'($signed(m_data_x)), prev_data);
        if (m_ready_x) begin
          if (xb < N) check("x_beat", int'($signed(m_data_x)), xm[xb]);
          xb++;
        end
      end
      prev_stall = m_valid_x && !m_ready_x;
      prev_data  = int'($signed(m_data_x));
      if (s_valid_y && s_ready_y && xb >= N) yi++;
      if (done) done_cnt++;
      if (done_cnt > 0) after++;
      if (after == 3) finished = 1'b1;
      if (abort_at > 0 && xb == abort_at) finished = 1'b1;
      tick();
      cyc++;
    end
    start     = 1'b0;
    h_wr_en   = 1'b0;
    s_valid_y = 1'b0;
    m_ready_x = 1'b0;

    if (abort_at > 0) begin
      check("abort_reached", xb, abort_at);
      y_ready_en = 1'b1;
      reset      = 1'b1;
      tick();
      @(negedge clk);
      check("rst_valid_x", int'(m_valid_x), 0);
      check("rst_ready_y", int'(s_ready_y), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_y_count", int'(y_count), 0);
      check("rst_y_sum", int'($signed(y_sum)), 0);
      check("rst_rd_data", int'(h_rd_data), 0);
      tick();
      reset = 1'b0;
      tick();
    end else begin
      for (int i = 0; i < NUM_Y; i++) exp_sum += yq[i];
      check("run_timeout", int'(finished), 1);
      check("x_beats", xb, N);
      check("y_accepted", yi, NUM_Y);
      check("done_pulses", done_cnt, 1);
      @(negedge clk);
      check("y_count", int'(y_count), NUM_Y);
      check("y_sum", int'($signed(y_sum)), exp_sum);
      check("busy_after", int'(busy), 0);
      check("done_after", int'(done), 0);
      tick();
    end
  endtask

  initial begin
    int nv;
    reset = 1'b1; h_wr_en = 1'b0; h_wr_addr = '0; h_wr_data = '0;
    h_rd_addr = '0; start = 1'b0; y_ready_en = 1'b1; m_ready_x = 1'b0;
    s_valid_y = 1'b0; s_data_y = '0;
    repeat (3) tick();
    reset = 1'b0;
    repeat (10) tick();
    @(negedge clk);
    check("idle_valid_x", int'(m_valid_x), 0);
    check("idle_ready_y", int'(s_ready_y), 0);
    check("idle_busy", int'(busy), 0);
    check("idle_done", int'(done), 0);
    check("idle_y_count", int'(y_count), 0);
    tick();

    // Ramp vector, constant Y of 3, with start pokes and an ignored busy write.
    for (int i = 0; i < N; i++) xm[i] = i - 64;
    for (int i = 0; i < NUM_Y; i++) yq[i] = 3;
    load_x();
    do_run(1'b0, 1'b1, 1'b0, 0);
    check("y_sum_ramp", int'($signed(y_sum)), 291);
    read_back();

    // Random vector, stalling X side, random Y, a write in the same cycle as start.
    for (int i = 0; i < N; i++) xm[i] = int'($urandom_range(0, 255)) - 128;
    for (int i = 0; i < NUM_Y; i++) yq[i] = int'($urandom_range(0, 255)) - 128;
    load_x();
    nv = ((xm[0] + 128 + 77) % 256) - 128;
    xm[0] = nv;
    do_run(1'b1, 1'b0, 1'b1, 0);
    read_back();

    // Reset after 50 X beats, then a full fresh run from x[0].
    for (int i = 0; i < NUM_Y; i++) yq[i] = int'($urandom_range(0, 255)) - 128;
    do_run(1'b0, 1'b0, 1'b0, 50);
    do_run(1'b0, 1'b0, 1'b0, 0);
    read_back();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
